// File: rtl/tcdm_port_arbiter_if.sv
// Bundle of the requester-side and interconnect-side TCDM signals around one shared port.
// slave: the arbiter's view. master: the environment (requesters + interconnect).
interface tcdm_port_arbiter_if #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned BeWidth   = DataWidth / 8
);
  // Requester side
  logic [NumReq-1:0]                req_i;
  logic [NumReq-1:0][AddrWidth-1:0] add_i;
  logic [NumReq-1:0]                wen_i;
  logic [NumReq-1:0][DataWidth-1:0] wdata_i;
  logic [NumReq-1:0][BeWidth-1:0]   be_i;
  logic [NumReq-1:0]                gnt_o;
  logic [NumReq-1:0]                vld_o;
  logic [NumReq-1:0][DataWidth-1:0] rdata_o;
  // Interconnect side
  logic                             req_o;
  logic [AddrWidth-1:0]             add_o;
  logic                             wen_o;
  logic [DataWidth-1:0]             wdata_o;
  logic [BeWidth-1:0]               be_o;
  logic                             gnt_i;
  logic                             vld_i;
  logic [DataWidth-1:0]             rdata_i;
  // Status
  logic                             err_o;

  modport slave (
    input  req_i, add_i, wen_i, wdata_i, be_i, gnt_i, vld_i, rdata_i,
    output gnt_o, vld_o, rdata_o, req_o, add_o, wen_o, wdata_o, be_o, err_o
  );

  modport master (
    output req_i, add_i, wen_i, wdata_i, be_i, gnt_i, vld_i, rdata_i,
    input  gnt_o, vld_o, rdata_o, req_o, add_o, wen_o, wdata_o, be_o, err_o
  );
endinterface

// File: rtl/tcdm_port_arbiter.sv
// Shares one tcdm_interconnect initiator port among NumReq requesters.
// Round-robin with request locking; responses routed in order through an index FIFO.
module tcdm_port_arbiter #(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned BeWidth     = DataWidth / 8,
  parameter int unsigned RespLat     = 1,
  parameter bit          WriteRespOn = 1'b1,
  parameter int unsigned MaxOutst    = RespLat + 1
) (
  input logic                clk_i,
  input logic                rst_ni,
  tcdm_port_arbiter_if.slave bus
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PtrW = (MaxOutst > 1) ? $clog2(MaxOutst) : 1;
  localparam int unsigned CntW = $clog2(MaxOutst + 1);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutst - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(MaxOutst);

  logic [IdxW-1:0] rr_q, rr_d;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic [IdxW-1:0] winner;
  logic            lock_hold;
  logic            found;
  int unsigned     scan_idx;
  logic [IdxW-1:0] scan_sel;

  logic [IdxW-1:0] idx_mem_q [MaxOutst];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic full, empty, hs, push, pop;

  assign full  = (cnt_q == FullCnt);
  assign empty = (cnt_q == '0);

  // Winner: the locked requester while it keeps requesting, else first requester from rr_q.
  always_comb begin
    winner    = '0;
    found     = 1'b0;
    scan_idx  = 0;
    scan_sel  = '0;
    lock_hold = lock_q & bus.req_i[lock_idx_q];
    if (lock_hold) begin
      winner = lock_idx_q;
    end else begin
      for (int unsigned k = 0; k < NumReq; k++) begin
        scan_idx = (32'(rr_q) + k) % NumReq;
        scan_sel = IdxW'(scan_idx);
        if (!found && bus.req_i[scan_sel]) begin
          winner = scan_sel;
          found  = 1'b1;
        end
      end
    end
  end

  // Interconnect-side request and payload mux; full blocks requests with no pop lookahead.
  assign bus.req_o   = (|bus.req_i) & ~full;
  assign bus.add_o   = bus.add_i[winner];
  assign bus.wen_o   = bus.wen_i[winner];
  assign bus.wdata_o = bus.wdata_i[winner];
  assign bus.be_o    = bus.be_i[winner];
  assign bus.err_o   = err_q;

  assign hs   = bus.req_o & bus.gnt_i;
  assign push = hs & (~bus.wen_o | WriteRespOn);
  assign pop  = bus.vld_i & ~empty;

  // Grant fan-out and in-order response routing to the FIFO head.
  always_comb begin
    bus.gnt_o = '0;
    bus.vld_o = '0;
    if (hs) begin
      bus.gnt_o[winner] = 1'b1;
    end
    if (pop) begin
      bus.vld_o[idx_mem_q[rd_ptr_q]] = 1'b1;
    end
    for (int unsigned i = 0; i < NumReq; i++) begin
      bus.rdata_o[i] = bus.rdata_i;
    end
  end

  // Arbitration state: advance pointer on handshake, lock an ungranted winner.
  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_hold;  // a locked requester that drops its request releases the lock
    lock_idx_d = lock_idx_q;
    if (hs) begin
      rr_d   = (winner == LastIdx) ? '0 : winner + IdxW'(1);
      lock_d = 1'b0;
    end else if (bus.req_o) begin
      lock_d     = 1'b1;
      lock_idx_d = winner;
    end
  end

  // Index FIFO pointers, occupancy and sticky error.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q | (bus.vld_i & empty);
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      idx_mem_q[wr_ptr_q] <= winner;
    end
  end

endmodule

// File: tb/tb_tcdm_port_arbiter.sv
// Self-checking bench: table of per-cycle vectors with expected outputs, response routing
// checked against a scoreboard queue of granted indices, plus reset sequences.
module tb_tcdm_port_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tcdm_port_arbiter_if #(.NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .BeWidth(BW)) a_if ();
  tcdm_port_arbiter_if #(.NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .BeWidth(BW)) b_if ();

  // A: writes respond, depth 2 (long response latency). B: writes complete at grant, depth 3.
  tcdm_port_arbiter #(
    .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .BeWidth(BW),
    .RespLat(4), .WriteRespOn(1'b1), .MaxOutst(2)
  ) dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (a_if)
  );

  tcdm_port_arbiter #(
    .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .BeWidth(BW),
    .RespLat(2), .WriteRespOn(1'b0), .MaxOutst(3)
  ) dut_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (b_if)
  );

  typedef struct {
    bit          sel;      // 0: dut_a, 1: dut_b
    logic [3:0]  req;
    logic [3:0]  wen;
    logic        gnt;
    logic        vld;
    logic        exp_req;
    int unsigned exp_win;
    logic [3:0]  exp_gnt;
    logic        exp_err;
  } vec_t;

  vec_t        tbl[$];
  int unsigned q_a[$];
  int unsigned q_b[$];
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add_vec(input bit sel, input logic [3:0] req, input logic [3:0] wen,
                                  input logic gnt, input logic vld, input logic exp_req,
                                  input int unsigned win, input logic [3:0] eg,
                                  input logic ee);
    vec_t v;
    v.sel = sel; v.req = req; v.wen = wen; v.gnt = gnt; v.vld = vld;
    v.exp_req = exp_req; v.exp_win = win; v.exp_gnt = eg; v.exp_err = ee;
    tbl.push_back(v);
  endfunction

  task automatic drive_a(input logic [3:0] req, input logic [3:0] wen, input logic gnt,
                         input logic vld, input logic [31:0] rd);
    a_if.req_i = req; a_if.wen_i = wen; a_if.gnt_i = gnt; a_if.vld_i = vld; a_if.rdata_i = rd;
  endtask

  task automatic drive_b(input logic [3:0] req, input logic [3:0] wen, input logic gnt,
                         input logic vld, input logic [31:0] rd);
    b_if.req_i = req; b_if.wen_i = wen; b_if.gnt_i = gnt; b_if.vld_i = vld; b_if.rdata_i = rd;
  endtask

  // One cycle: drive, check combinational outputs mid-cycle, update scoreboard, pass the edge.
  task automatic apply(input vec_t v, input int n);
    logic [3:0]  exp_vld;
    logic [31:0] rd;
    logic        o_req, o_wen, o_err;
    logic [3:0]  o_gnt, o_vld;
    logic [31:0] o_add, o_rd, base;
    int unsigned idx;
    exp_vld = '0;
    rd      = $urandom();
    if (!v.sel) begin
      drive_a(v.req, v.wen, v.gnt, v.vld, rd);
      drive_b(4'b0, 4'b0, 1'b0, 1'b0, 32'h0);
      if (v.vld && q_a.size() > 0) begin
        idx = q_a.pop_front();
        exp_vld = 4'(1 << idx);
      end
    end else begin
      drive_b(v.req, v.wen, v.gnt, v.vld, rd);
      drive_a(4'b0, 4'b0, 1'b0, 1'b0, 32'h0);
      if (v.vld && q_b.size() > 0) begin
        idx = q_b.pop_front();
        exp_vld = 4'(1 << idx);
      end
    end
    @(negedge clk);
    if (!v.sel) begin
      o_req = a_if.req_o; o_gnt = a_if.gnt_o; o_vld = a_if.vld_o; o_err = a_if.err_o;
      o_add = a_if.add_o; o_wen = a_if.wen_o; o_rd = a_if.rdata_o[3]; base = 32'hA000_0000;
    end else begin
      o_req = b_if.req_o; o_gnt = b_if.gnt_o; o_vld = b_if.vld_o; o_err = b_if.err_o;
      o_add = b_if.add_o; o_wen = b_if.wen_o; o_rd = b_if.rdata_o[3]; base = 32'hB000_0000;
    end
    check($sformatf("v%0d req_o", n), 64'(o_req), 64'(v.exp_req));
    check($sformatf("v%0d gnt_o", n), 64'(o_gnt), 64'(v.exp_gnt));
    check($sformatf("v%0d vld_o", n), 64'(o_vld), 64'(exp_vld));
    check($sformatf("v%0d err_o", n), 64'(o_err), 64'(v.exp_err));
    check($sformatf("v%0d add_o", n), 64'(o_add), 64'(base | v.exp_win));
    check($sformatf("v%0d wen_o", n), 64'(o_wen), 64'(v.wen[v.exp_win[1:0]]));
    if (v.vld) check($sformatf("v%0d rdata_o", n), 64'(o_rd), 64'(rd));
    // Expected FIFO push: every handshake on A, only loads on B.
    if (v.exp_gnt != 4'b0) begin
      if (!v.sel) q_a.push_back(v.exp_win);
      else if (!v.wen[v.exp_win[1:0]]) q_b.push_back(v.exp_win);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 4; i++) begin
      a_if.add_i[i]   = 32'hA000_0000 | 32'(i);
      b_if.add_i[i]   = 32'hB000_0000 | 32'(i);
      a_if.wdata_i[i] = 32'hD000_0000 | 32'(i);
      b_if.wdata_i[i] = 32'hE000_0000 | 32'(i);
      a_if.be_i[i]    = 4'(1 << i);
      b_if.be_i[i]    = 4'(1 << i);
    end

    //        sel req      wen      gnt   vld   req_o win gnt_o    err
    // T1/T2: reset release with all requesting, then round robin with 1-cycle responses
    add_vec(0, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 0, 4'b0001, 1'b0);
    add_vec(0, 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b1, 1, 4'b0010, 1'b0);
    add_vec(0, 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b1, 2, 4'b0100, 1'b0);
    add_vec(0, 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b1, 3, 4'b1000, 1'b0);
    add_vec(0, 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b1, 0, 4'b0001, 1'b0);
    add_vec(0, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b1, 2, 4'b0100, 1'b0);
    add_vec(0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 4'b0000, 1'b0);
    // T3: lock on idx1 (rr=3); req[0] rising must not steal the port
    add_vec(0, 4'b0110, 4'b0000, 1'b0, 1'b0, 1'b1, 1, 4'b0000, 1'b0);
    add_vec(0, 4'b0110, 4'b0000, 1'b0, 1'b0, 1'b1, 1, 4'b0000, 1'b0);
    add_vec(0, 4'b0110, 4'b0000, 1'b0, 1'b0, 1'b1, 1, 4'b0000, 1'b0);
    add_vec(0, 4'b0111, 4'b0000, 1'b0, 1'b0, 1'b1, 1, 4'b0000, 1'b0);
    add_vec(0, 4'b0111, 4'b0000, 1'b1, 1'b0, 1'b1, 1, 4'b0010, 1'b0);
    add_vec(0, 4'b0101, 4'b0000, 1'b1, 1'b1, 1'b1, 2, 4'b0100, 1'b0);
    add_vec(0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 4'b0000, 1'b0);
    // Locked requester drops: lock releases the same cycle
    add_vec(0, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b1, 3, 4'b0000, 1'b0);
    add_vec(0, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 0, 4'b0000, 1'b0);
    add_vec(0, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1, 0, 4'b0001, 1'b0);
    add_vec(0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 4'b0000, 1'b0);
    // T4: depth 2, 4-cycle responses; full blocks, push+pop at count 1 keeps count 1
    add_vec(0, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 1, 4'b0010, 1'b0);
    add_vec(0, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 2, 4'b0100, 1'b0);
    add_vec(0, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 3, 4'b0000, 1'b0);
    add_vec(0, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 3, 4'b0000, 1'b0);
    add_vec(0, 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b0, 3, 4'b0000, 1'b0);
    add_vec(0, 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b1, 3, 4'b1000, 1'b0);
    add_vec(0, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 0, 4'b0001, 1'b0);
    add_vec(0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 4'b0000, 1'b0);
    add_vec(0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 4'b0000, 1'b0);
    // T6: spurious response with empty FIFO, err sticky
    add_vec(0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 4'b0000, 1'b0);
    add_vec(0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 4'b0000, 1'b1);
    add_vec(0, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1, 0, 4'b0001, 1'b1);
    add_vec(0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 4'b0000, 1'b1);
    // T5 on B: store from idx2 gets no response slot; idx3 load takes the next vld
    add_vec(1, 4'b0100, 4'b0100, 1'b1, 1'b0, 1'b1, 2, 4'b0100, 1'b0);
    add_vec(1, 4'b1000, 4'b0000, 1'b1, 1'b0, 1'b1, 3, 4'b1000, 1'b0);
    add_vec(1, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 4'b0000, 1'b0);
    // B depth 3: fill, block, drain across pointer wrap
    add_vec(1, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1, 0, 4'b0001, 1'b0);
    add_vec(1, 4'b0010, 4'b0000, 1'b1, 1'b0, 1'b1, 1, 4'b0010, 1'b0);
    add_vec(1, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1, 2, 4'b0100, 1'b0);
    add_vec(1, 4'b1000, 4'b0000, 1'b1, 1'b0, 1'b0, 3, 4'b0000, 1'b0);
    add_vec(1, 4'b1000, 4'b0000, 1'b1, 1'b1, 1'b0, 3, 4'b0000, 1'b0);
    add_vec(1, 4'b1000, 4'b0000, 1'b1, 1'b1, 1'b1, 3, 4'b1000, 1'b0);
    add_vec(1, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 4'b0000, 1'b0);
    add_vec(1, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 4'b0000, 1'b0);
    add_vec(1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 4'b0000, 1'b0);

    // Reset for two cycles with all of A requesting
    drive_a(4'b1111, 4'b0000, 1'b0, 1'b0, 32'h0);
    drive_b(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst b req_o", 64'(b_if.req_o), 64'h0);
    check("rst b gnt_o", 64'(b_if.gnt_o), 64'h0);
    check("rst b vld_o", 64'(b_if.vld_o), 64'h0);
    check("rst b err_o", 64'(b_if.err_o), 64'h0);
    check("rst a err_o", 64'(a_if.err_o), 64'h0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Reset mid-operation: outstanding entry discarded, err cleared, late response flags err
    v = '{sel: 1'b0, req: 4'b0001, wen: 4'b0, gnt: 1'b1, vld: 1'b0, exp_req: 1'b1,
          exp_win: 0, exp_gnt: 4'b0001, exp_err: 1'b1};
    apply(v, 100);
    drive_a(4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q_a.delete();
    check("rst2 a err_o", 64'(a_if.err_o), 64'h0);
    check("rst2 a req_o", 64'(a_if.req_o), 64'h0);
    check("rst2 a gnt_o", 64'(a_if.gnt_o), 64'h0);
    check("rst2 a vld_o", 64'(a_if.vld_o), 64'h0);
    v = '{sel: 1'b0, req: 4'b0, wen: 4'b0, gnt: 1'b0, vld: 1'b1, exp_req: 1'b0,
          exp_win: 0, exp_gnt: 4'b0, exp_err: 1'b0};
    apply(v, 101);
    v.vld = 1'b0;
    v.exp_err = 1'b1;
    apply(v, 102);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
